// File: rtl/fmap_skew_reader.sv
// fmap_skew_reader
//   Streams NUM_ROWS consecutive feature-map words out of a synchronous
//   read memory and presents them to a systolic array with a diagonal
//   skew: lane i of each word is delayed i cycles relative to lane 0.
//
// Ports
//   clk, rst_n      single clock, asynchronous active-low reset
//   start_i         one-cycle run request (accepted only in IDLE)
//   base_addr_i     first memory address, sampled with start_i
//   mem_q_i         memory read data, one cycle after mem_ce_o
//   mem_addr_o      memory read address (0 outside READ)
//   mem_ce_o        memory chip enable (READ only)
//   mem_we_o        memory write enable, tied low
//   fmap_row_o      skewed lane data, lane i = [(i+1)*DATA_WIDTH-1 -: DATA_WIDTH]
//   lane_valid_o    per-lane valid, bit i qualifies lane i
//   busy_o          high through READ and DRAIN
//   done_o          one-cycle pulse in DONE
module fmap_skew_reader #(
  parameter int DATA_WIDTH     = 8,
  parameter int PE_SIZE        = 14,
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int MEM_DATA_WIDTH = 112,
  parameter int NUM_ROWS       = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  input  logic [MEM_ADDR_WIDTH-1:0] base_addr_i,
  input  logic [MEM_DATA_WIDTH-1:0] mem_q_i,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
  output logic                      mem_ce_o,
  output logic                      mem_we_o,
  output logic [MEM_DATA_WIDTH-1:0] fmap_row_o,
  output logic [PE_SIZE-1:0]        lane_valid_o,
  output logic                      busy_o,
  output logic                      done_o
);

  // One counter serves both READ (row index) and DRAIN (drain cycle index).
  localparam int CNT_W = $clog2(NUM_ROWS + PE_SIZE + 2);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t                    state;
  state_t                    next_state;
  logic [CNT_W-1:0]          cnt;
  logic [MEM_ADDR_WIDTH-1:0] base_addr;
  logic                      last_read;
  logic                      last_drain;
  logic                      read_pending;
  logic [PE_SIZE-1:0]        valid_pipe;

  assign last_read  = (cnt == CNT_W'(NUM_ROWS - 1));
  // DRAIN lasts PE_SIZE+1 cycles: one for the output register, PE_SIZE-1
  // for the deepest lane's delay line, one for its final row to be shown.
  assign last_drain = (cnt == CNT_W'(PE_SIZE));

  // State register, phase counter and latched base address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      base_addr <= '0;
    end else begin
      state <= next_state;
      cnt   <= (next_state != state) ? '0 : cnt + CNT_W'(1);
      if (state == IDLE && start_i)
        base_addr <= base_addr_i;
    end
  end

  // Next-state logic; start_i only matters in IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_i)    next_state = READ;
      READ:    if (last_read)  next_state = DRAIN;
      DRAIN:   if (last_drain) next_state = DONE;
      DONE:                    next_state = IDLE;
      default:                 next_state = IDLE;
    endcase
  end

  // Memory interface and status outputs decoded from the state.
  always_comb begin
    mem_ce_o   = 1'b0;
    mem_addr_o = '0;
    mem_we_o   = 1'b0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    case (state)
      READ: begin
        mem_ce_o   = 1'b1;
        mem_addr_o = base_addr + MEM_ADDR_WIDTH'(cnt);
        busy_o     = 1'b1;
      end
      DRAIN:   busy_o = 1'b1;
      DONE:    done_o = 1'b1;
      default: ;
    endcase
  end

  // read_pending marks the cycle in which mem_q_i holds a word of this run;
  // valid_pipe shifts that marker one lane per cycle to form the skew.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_pending <= 1'b0;
      valid_pipe   <= '0;
    end else begin
      read_pending <= mem_ce_o;
      valid_pipe   <= {valid_pipe[PE_SIZE-2:0], read_pending};
    end
  end

  assign lane_valid_o = valid_pipe;

  // Lane i keeps an (i+1)-deep delay line: stage 0 registers the memory
  // word, the remaining i stages provide the skew. Non-run data is loaded
  // as zero so nothing stale travels down the lines.
  for (genvar i = 0; i < PE_SIZE; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] line [0:i];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s <= i; s++)
          line[s] <= '0;
      end else begin
        line[0] <= read_pending ? mem_q_i[(i+1)*DATA_WIDTH-1 -: DATA_WIDTH] : '0;
        for (int s = 1; s <= i; s++)
          line[s] <= line[s-1];
      end
    end

    assign fmap_row_o[(i+1)*DATA_WIDTH-1 -: DATA_WIDTH] = valid_pipe[i] ? line[i] : '0;
  end

endmodule

// File: tb/tb_fmap_skew_reader.sv
// tb_fmap_skew_reader
//   Randomized scoreboard bench for fmap_skew_reader with default
//   parameters. Each accepted start pushes one expected record per cycle
//   of the run; a monitor pops a record every cycle (or expects idle
//   outputs when the queue is empty) and compares all outputs.
module tb_fmap_skew_reader;

  localparam int DW    = 8;
  localparam int PE    = 14;
  localparam int AW    = 10;
  localparam int MW    = DW * PE;
  localparam int NR    = 64;
  localparam int DEPTH = 1 << AW;
  localparam int TOTAL = NR + PE + 2;

  typedef struct {
    logic [AW-1:0] addr;
    logic          ce;
    logic          busy;
    logic          done;
    logic [PE-1:0] valid;
    logic [MW-1:0] row;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          start_i;
  logic [AW-1:0] base_addr_i;
  logic [MW-1:0] mem_q_i;
  logic [AW-1:0] mem_addr_o;
  logic          mem_ce_o;
  logic          mem_we_o;
  logic [MW-1:0] fmap_row_o;
  logic [PE-1:0] lane_valid_o;
  logic          busy_o;
  logic          done_o;

  logic [MW-1:0] mem_arr [DEPTH];
  exp_t          exp_q [$];
  int            total_checks = 0;
  int            fail_count   = 0;

  fmap_skew_reader #(
    .DATA_WIDTH(DW), .PE_SIZE(PE), .MEM_ADDR_WIDTH(AW),
    .MEM_DATA_WIDTH(MW), .NUM_ROWS(NR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .base_addr_i(base_addr_i),
    .mem_q_i(mem_q_i), .mem_addr_o(mem_addr_o), .mem_ce_o(mem_ce_o),
    .mem_we_o(mem_we_o), .fmap_row_o(fmap_row_o), .lane_valid_o(lane_valid_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous-read memory; returns noise when not enabled so that any
  // leakage of non-run data into the lanes is visible.
  always @(posedge clk) begin
    if (mem_ce_o)
      mem_q_i <= mem_arr[mem_addr_o];
    else
      mem_q_i <= MW'({$urandom, $urandom, $urandom, $urandom});
  end

  function automatic void fillPattern();
    for (int j = 0; j < DEPTH; j++)
      for (int l = 0; l < PE; l++)
        mem_arr[j][l*DW +: DW] = DW'(j + l);
  endfunction

  function automatic void fillRandom();
    for (int j = 0; j < DEPTH; j++)
      mem_arr[j] = MW'({$urandom, $urandom, $urandom, $urandom});
  endfunction

  // Reference model: cycle c of a run reads row c while c < NR, and lane i
  // shows row c-2-i when that row exists.
  function automatic void pushExpected(int base);
    exp_t e;
    int   k;
    for (int c = 0; c < TOTAL; c++) begin
      e.ce    = (c < NR);
      e.addr  = e.ce ? AW'((base + c) % DEPTH) : '0;
      e.busy  = (c <= NR + PE);
      e.done  = (c == NR + PE + 1);
      e.valid = '0;
      e.row   = '0;
      for (int i = 0; i < PE; i++) begin
        k = c - 2 - i;
        if (k >= 0 && k < NR) begin
          e.valid[i]        = 1'b1;
          e.row[i*DW +: DW] = mem_arr[(base + k) % DEPTH][i*DW +: DW];
        end
      end
      exp_q.push_back(e);
    end
  endfunction

  task automatic checkField(input string name, input logic [127:0] act, input logic [127:0] req);
    total_checks++;
    if (act !== req) begin
      fail_count++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkField("mem_addr_o", 128'(mem_addr_o), 128'(e.addr));
    checkField("mem_ce_o", 128'(mem_ce_o), 128'(e.ce));
    checkField("mem_we_o", 128'(mem_we_o), 128'(0));
    checkField("busy_o", 128'(busy_o), 128'(e.busy));
    checkField("done_o", 128'(done_o), 128'(e.done));
    checkField("lane_valid_o", 128'(lane_valid_o), 128'(e.valid));
    checkField("fmap_row_o", 128'(fmap_row_o), 128'(e.row));
  endtask

  // Monitor: one record per cycle, idle expectations when nothing queued.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
    end else begin
      e.addr = '0; e.ce = 1'b0; e.busy = 1'b0; e.done = 1'b0;
      e.valid = '0; e.row = '0;
    end
    checkOutput(e);
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // One run: start issued now (IDLE), optional ignored starts at READ
  // cycle 5 and in DONE, optional reset at cycle abort_at.
  task automatic applyStimulus(input int base, input bit mid_start,
                               input bit done_start, input int abort_at);
    base_addr_i = AW'(base);
    start_i     = 1'b1;
    @(posedge clk);
    pushExpected(base);
    #1;
    start_i = 1'b0;
    for (int c = 0; c < TOTAL; c++) begin
      if (c == abort_at) begin
        rst_n = 1'b0;
        exp_q.delete();
        nextCycle();
        rst_n = 1'b1;
        repeat (3) nextCycle();
        return;
      end
      base_addr_i = AW'($urandom_range(DEPTH - 1));
      start_i     = (mid_start && c == 5) || (done_start && c == TOTAL - 1);
      nextCycle();
    end
    start_i = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    start_i     = 1'b0;
    base_addr_i = '0;
    fillPattern();
    repeat (3) nextCycle();
    rst_n = 1'b1;
    repeat (2) nextCycle();

    $display("[TB] nominal run, base 0");
    applyStimulus(0, 1'b0, 1'b0, -1);
    repeat (2) nextCycle();

    $display("[TB] wrap run with ignored starts");
    fillRandom();
    applyStimulus(1020, 1'b1, 1'b1, -1);
    $display("[TB] back-to-back runs");
    applyStimulus(int'($urandom_range(DEPTH - 1)), 1'b0, 1'b0, -1);
    applyStimulus(int'($urandom_range(DEPTH - 1)), 1'b0, 1'b0, -1);
    repeat (2) nextCycle();

    $display("[TB] mid-run reset then clean run");
    applyStimulus(int'($urandom_range(DEPTH - 1)), 1'b0, 1'b0, 10);
    applyStimulus(int'($urandom_range(DEPTH - 1)), 1'b0, 1'b0, -1);

    for (int r = 0; r < 3; r++) begin
      fillRandom();
      repeat (int'($urandom_range(3))) nextCycle();
      applyStimulus(int'($urandom_range(DEPTH - 1)), 1'($urandom), 1'($urandom), -1);
    end

    repeat (4) nextCycle();
    checkField("scoreboard_drained", 128'(exp_q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", total_checks, fail_count);
    $finish;
  end

  // Safety net against a stuck simulation.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
